// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - Gray-code step monitor with lap counting; optional backward steps via GRAY_MON_BACKWARD_EN
module gray_step_monitor #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             Valid_in,
  input  logic [WIDTH-1:0] Gray_in,
  output logic [WIDTH-1:0] Bin_out,
  output logic             Locked,
  output logic [CNT_W-1:0] Laps,
  output logic             Lap_sat,
  output logic             Step_err
);

  localparam logic [1:0] ST_UNLOCKED = 2'b00;
  localparam logic [1:0] ST_LOCKED   = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;

  localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] BIN_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAPS_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAPS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] delta;

  // Gray to binary: each binary bit is the parity of the Gray bits at and above it
  always_comb begin
    new_bin = BIN_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      new_bin[i] = ^(Gray_in >> i);
    end
  end

  // Step size relative to the last accepted sample, wrapping naturally in WIDTH bits
  always_comb begin
    delta = new_bin - Bin_out;
  end

  // Lock/step/lap tracking; ERROR (and the unused 4th code) is left only via Clear or reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_UNLOCKED;
      Bin_out  <= BIN_ZERO;
      Locked   <= 1'b0;
      Laps     <= '0;
      Lap_sat  <= 1'b0;
      Step_err <= 1'b0;
    end else if (Clear) begin
      state    <= ST_UNLOCKED;
      Bin_out  <= BIN_ZERO;
      Locked   <= 1'b0;
      Laps     <= '0;
      Lap_sat  <= 1'b0;
      Step_err <= 1'b0;
    end else if (Valid_in) begin
      case (state)
        ST_UNLOCKED: begin
          Bin_out <= new_bin;
          Locked  <= 1'b1;
          state   <= ST_LOCKED;
        end
        ST_LOCKED: begin
          if (delta == BIN_ZERO) begin
            state <= ST_LOCKED;
          end else if (delta == BIN_ONE) begin
            Bin_out <= new_bin;
            if (Bin_out == BIN_MAX) begin
              if (Laps == LAPS_MAX) begin
                Lap_sat <= 1'b1;
              end else begin
                Laps <= Laps + LAPS_ONE;
              end
            end
`ifdef GRAY_MON_BACKWARD_EN
          end else if (delta == BIN_MAX) begin
            Bin_out <= new_bin;
            if ((Bin_out == BIN_ZERO) && (Laps != '0)) begin
              Laps <= Laps - LAPS_ONE;
            end
`endif
          end else begin
            Step_err <= 1'b1;
            state    <= ST_ERROR;
          end
        end
        default: begin
          state <= ST_ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb/tb_gray_step_monitor.sv - randomized self-checking bench for gray_step_monitor against a lap/step model
module tb_gray_step_monitor;

  localparam int W    = 3;
  localparam int CW   = 8;
  localparam int NCODE = 1 << W;
  localparam int LMAX  = (1 << CW) - 1;

  logic          Clk;
  logic          Reset_n;
  logic          Clear;
  logic          Valid_in;
  logic [W-1:0]  Gray_in;
  logic [W-1:0]  Bin_out;
  logic          Locked;
  logic [CW-1:0] Laps;
  logic          Lap_sat;
  logic          Step_err;

  gray_step_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .Valid_in(Valid_in),
    .Gray_in(Gray_in), .Bin_out(Bin_out), .Locked(Locked), .Laps(Laps),
    .Lap_sat(Lap_sat), .Step_err(Step_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = waiting for reference, 1 = tracking, 2 = failed
  int m_mode, m_bin, m_laps, m_sat, m_err;
  int g2b [NCODE];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_gray(input int b);
    int bm;
    bm = ((b % NCODE) + NCODE) % NCODE;
    return W'(bm ^ (bm >> 1));
  endfunction

  task automatic model_zero();
    m_mode = 0; m_bin = 0; m_laps = 0; m_sat = 0; m_err = 0;
  endtask

  task automatic model_update(input logic c, input logic v, input logic [W-1:0] g);
    int nb, d;
    if (c) begin
      model_zero();
    end else if (v) begin
      nb = g2b[int'(g)];
      d  = (nb - m_bin + NCODE) % NCODE;
      if (m_mode == 0) begin
        m_bin = nb; m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == 0) begin
        end else if (d == 1) begin
          if (m_bin == NCODE - 1) begin
            if (m_laps == LMAX) m_sat = 1;
            else m_laps++;
          end
          m_bin = nb;
`ifdef GRAY_MON_BACKWARD_EN
        end else if (d == NCODE - 1) begin
          if (m_bin == 0 && m_laps > 0) m_laps--;
          m_bin = nb;
`endif
        end else begin
          m_err = 1; m_mode = 2;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_bin"},    32'(Bin_out),  32'(m_bin));
    check({tag, "_locked"}, 32'(Locked),   32'(m_mode != 0));
    check({tag, "_laps"},   32'(Laps),     32'(m_laps));
    check({tag, "_sat"},    32'(Lap_sat),  32'(m_sat));
    check({tag, "_err"},    32'(Step_err), 32'(m_err));
  endtask

  // Called at a falling edge; applies inputs across one rising edge and checks at the next falling edge
  task automatic step(input logic c, input logic v, input logic [W-1:0] g, input string tag, input bit chk);
    Clear = c; Valid_in = v; Gray_in = g;
    @(posedge Clk);
    model_update(c, v, g);
    @(negedge Clk);
    Clear = 1'b0; Valid_in = 1'b0;
    if (chk) check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 Reset_n = 1'b0;
    #1;
    model_zero();
    check({tag, "_rst_bin"},    32'(Bin_out),  32'd0);
    check({tag, "_rst_locked"}, 32'(Locked),   32'd0);
    check({tag, "_rst_laps"},   32'(Laps),     32'd0);
    check({tag, "_rst_err"},    32'(Step_err), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_all({tag, "_post"});
  endtask

  initial begin
    for (int b = 0; b < NCODE; b++) g2b[b ^ (b >> 1)] = b;
    Reset_n = 1'b0; Clear = 1'b0; Valid_in = 1'b0; Gray_in = '0;
    model_zero();
    @(negedge Clk); @(negedge Clk);
    check_all("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    // 1: reset mid-count
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, to_gray(i), "t1_run", 1'b1);
    async_reset("t1");

    // 2: one full forward lap
    for (int i = 0; i <= NCODE; i++) step(1'b0, 1'b1, to_gray(i), "t2", 1'b1);
    check("t2_bin_wrapped", 32'(Bin_out), 32'd0);
    check("t2_laps_one",    32'(Laps),    32'd1);
    check("t2_no_err",      32'(Step_err), 32'd0);

    // 3: illegal jump, ignored sample in ERROR, then Clear
    step(1'b1, 1'b0, '0, "t3_clr", 1'b1);
    step(1'b0, 1'b1, 3'b011, "t3_lock", 1'b1);
    step(1'b0, 1'b1, 3'b111, "t3_jump", 1'b1);
    check("t3_err_set", 32'(Step_err), 32'd1);
    check("t3_bin_hold", 32'(Bin_out), 32'd2);
    step(1'b0, 1'b1, 3'b010, "t3_ignored", 1'b1);
    check("t3_still_err", 32'(Step_err), 32'd1);
    check("t3_still_locked", 32'(Locked), 32'd1);
    step(1'b1, 1'b0, '0, "t3_clear", 1'b1);
    check("t3_clear_locked", 32'(Locked), 32'd0);

    // 4: saturate lap counter with idle gaps in the stream
    step(1'b0, 1'b1, 3'b000, "t4_lock", 1'b1);
    for (int i = 1; i <= NCODE * (LMAX + 1); i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, W'($urandom), "t4_gap", 1'b1);
      step(1'b0, 1'b1, to_gray(i), "t4", (i % NCODE) == 0);
    end
    check("t4_laps_max", 32'(Laps),    32'(LMAX));
    check("t4_sat",      32'(Lap_sat), 32'd1);
    check("t4_no_err",   32'(Step_err), 32'd0);

    // 5: single backward step from 0
    step(1'b1, 1'b0, '0, "t5_clr", 1'b1);
    step(1'b0, 1'b1, 3'b000, "t5_lock", 1'b1);
    step(1'b0, 1'b1, 3'b100, "t5_back", 1'b1);
`ifdef GRAY_MON_BACKWARD_EN
    check("t5_bin", 32'(Bin_out), 32'd7);
    check("t5_laps", 32'(Laps), 32'd0);
    check("t5_err", 32'(Step_err), 32'd0);
`else
    check("t5_err", 32'(Step_err), 32'd1);
`endif

    // 6: Clear beats a simultaneous valid sample
    step(1'b1, 1'b0, '0, "t6_clr", 1'b1);
    step(1'b0, 1'b1, 3'b011, "t6_lock", 1'b1);
    step(1'b1, 1'b1, 3'b001, "t6_clr_valid", 1'b1);
    check("t6_bin0", 32'(Bin_out), 32'd0);
    check("t6_unlocked", 32'(Locked), 32'd0);
    step(1'b0, 1'b1, 3'b001, "t6_relock", 1'b1);
    check("t6_bin1", 32'(Bin_out), 32'd1);
    check("t6_locked", 32'(Locked), 32'd1);

    // Random mix of legal steps, backward steps, repeats, jumps, gaps and clears
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [W-1:0] g;
      r = $urandom_range(0, 19);
      if (r < 10)      g = to_gray(m_bin + 1);
      else if (r < 14) g = to_gray(m_bin - 1);
      else if (r < 16) g = to_gray(m_bin);
      else             g = W'($urandom);
      if (n == 700) async_reset("rnd");
      step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, g, "rnd", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
